// File: rtl/pkt_pkg.sv
// Shared state encodings, header word indices and defaults for the packet receive parser.
// PKT_LEN follows the PKT_CHECKSUM_EN build macro (6 words with checksum, 5 without).
package pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CHECK,
        ISSUE,
        WAIT
    } pkt_state_e;

    localparam logic [2:0] IDX_SRC = 3'd1;
    localparam logic [2:0] IDX_DST = 3'd2;
    localparam logic [2:0] IDX_CLU = 3'd3;
    localparam logic [2:0] IDX_BAT = 3'd4;
    localparam logic [2:0] IDX_VAL = 3'd5;
    localparam logic [2:0] IDX_CHK = 3'd6;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hA5A5;
    localparam logic [15:0] DEF_BCAST_ID  = 16'hFFFF;

`ifdef PKT_CHECKSUM_EN
    localparam logic [2:0] PKT_LEN = IDX_CHK;
`else
    localparam logic [2:0] PKT_LEN = IDX_VAL;
`endif

endpackage

// File: rtl/pkt_checksum.sv
// Running modulo-2^WIDTH accumulator over the header words; cleared at each sync word.
// Only instantiated when PKT_CHECKSUM_EN is defined.
module pkt_checksum #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             nrst,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] r_sum;

    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/pkt_rx_parser.sv
// Sync-word hunting header parser: stages src/dest/cluster/battery/value, filters on
// destination, issues a one-cycle en and waits for done_reward or a timeout. Macro: PKT_CHECKSUM_EN.
module pkt_rx_parser
    import pkt_pkg::*;
#(
    parameter int                    WORD_WIDTH   = 16,
    parameter logic [WORD_WIDTH-1:0] SYNC_WORD    = DEF_SYNC_WORD,
    parameter int                    NODE_ID      = 3,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID     = DEF_BCAST_ID,
    parameter int                    WAIT_TIMEOUT = 1023
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  done_reward,
    output logic                  en,
    output logic [WORD_WIDTH-1:0] fsourceID,
    output logic [WORD_WIDTH-1:0] fdestinationID,
    output logic [WORD_WIDTH-1:0] fclusterID,
    output logic [WORD_WIDTH-1:0] fbatteryStat,
    output logic [WORD_WIDTH-1:0] fValue,
    output logic                  pkt_err,
    output logic [7:0]            drop_cnt
);

    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    pkt_state_e            r_state, w_state_nxt;
    logic [2:0]            r_idx;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_in_ready, r_en, r_pkt_err;
    logic [7:0]            r_drop_cnt;
    logic [WORD_WIDTH-1:0] r_stg_src, r_stg_dst, r_stg_clu, r_stg_bat, r_stg_val;
    logic [WORD_WIDTH-1:0] r_f_src, r_f_dst, r_f_clu, r_f_bat, r_f_val;
    logic                  w_xfer, w_sync, w_dest_ok, w_chk_ok, w_drop, w_err;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_sync    = w_xfer && (in_data == SYNC_WORD);
    assign w_dest_ok = (r_stg_dst == WORD_WIDTH'(NODE_ID)) || (r_stg_dst == BCAST_ID);

`ifdef PKT_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] r_stg_chk;
    logic [WORD_WIDTH-1:0] w_sum;

    pkt_checksum #(.WIDTH(WORD_WIDTH)) u_checksum (
        .clock  (clock),
        .nrst   (nrst),
        .i_clr  ((r_state == IDLE) && w_sync),
        .i_add  ((r_state == HDR) && w_xfer && (r_idx != IDX_CHK)),
        .i_data (in_data),
        .o_sum  (w_sum)
    );

    assign w_chk_ok = (w_sum == r_stg_chk);

    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_stg_chk <= '0;
        end else if ((r_state == HDR) && w_xfer && (r_idx == IDX_CHK)) begin
            r_stg_chk <= in_data;
        end
    end
`else
    assign w_chk_ok = 1'b1;
`endif

    // Destination filter is evaluated before the checksum: a foreign packet is dropped silently.
    always_comb begin
        w_state_nxt = r_state;
        w_drop      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE:  if (w_sync) w_state_nxt = HDR;
            HDR:   if (w_xfer && (r_idx == PKT_LEN)) w_state_nxt = CHECK;
            CHECK: begin
                if (!w_dest_ok) begin
                    w_state_nxt = IDLE;
                    w_drop      = 1'b1;
                end else if (!w_chk_ok) begin
                    w_state_nxt = IDLE;
                    w_drop      = 1'b1;
                    w_err       = 1'b1;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (done_reward) begin
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == CNT_W'(WAIT_TIMEOUT)) begin
                    w_state_nxt = IDLE;
                    w_drop      = 1'b1;
                    w_err       = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_en       <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_drop_cnt <= '0;
            r_idx      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == IDLE) || (w_state_nxt == HDR);
            r_en       <= (w_state_nxt == ISSUE);
            r_pkt_err  <= w_err;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if ((r_state == IDLE) && w_sync) begin
                r_idx <= IDX_SRC;
            end else if ((r_state == HDR) && w_xfer) begin
                r_idx <= r_idx + 3'd1;
            end
            if (r_state == ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_stg_src <= '0;
            r_stg_dst <= '0;
            r_stg_clu <= '0;
            r_stg_bat <= '0;
            r_stg_val <= '0;
        end else if ((r_state == HDR) && w_xfer) begin
            case (r_idx)
                IDX_SRC: r_stg_src <= in_data;
                IDX_DST: r_stg_dst <= in_data;
                IDX_CLU: r_stg_clu <= in_data;
                IDX_BAT: r_stg_bat <= in_data;
                IDX_VAL: r_stg_val <= in_data;
                default: ;
            endcase
        end
    end

    // Field outputs load on entry to ISSUE so they are valid in the same cycle as en.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_f_src <= '0;
            r_f_dst <= '0;
            r_f_clu <= '0;
            r_f_bat <= '0;
            r_f_val <= '0;
        end else if (w_state_nxt == ISSUE) begin
            r_f_src <= r_stg_src;
            r_f_dst <= r_stg_dst;
            r_f_clu <= r_stg_clu;
            r_f_bat <= r_stg_bat;
            r_f_val <= r_stg_val;
        end
    end

    assign in_ready       = r_in_ready;
    assign en             = r_en;
    assign pkt_err        = r_pkt_err;
    assign drop_cnt       = r_drop_cnt;
    assign fsourceID      = r_f_src;
    assign fdestinationID = r_f_dst;
    assign fclusterID     = r_f_clu;
    assign fbatteryStat   = r_f_bat;
    assign fValue         = r_f_val;

endmodule

// File: tb/tb_pkt_rx_parser.sv
// Self-checking bench for pkt_rx_parser: directed scenarios plus randomized packets
// compared against a packet-level reference model (expected fields, pulse counts, drop count).
module tb_pkt_rx_parser;

    localparam logic [15:0] SYNC  = 16'hA5A5;
    localparam logic [15:0] BCAST = 16'hFFFF;
    localparam logic [15:0] NODE  = 16'd3;
    localparam int          TO    = 1023;

    logic        clock = 1'b0;
    logic        nrst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        done_reward = 1'b0;
    logic        in_ready, en, pkt_err;
    logic [15:0] fsourceID, fdestinationID, fclusterID, fbatteryStat, fValue;
    logic [7:0]  drop_cnt;

    pkt_rx_parser dut (
        .clock          (clock),
        .nrst           (nrst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .done_reward    (done_reward),
        .en             (en),
        .fsourceID      (fsourceID),
        .fdestinationID (fdestinationID),
        .fclusterID     (fclusterID),
        .fbatteryStat   (fbatteryStat),
        .fValue         (fValue),
        .pkt_err        (pkt_err),
        .drop_cnt       (drop_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, en_cnt = 0, err_cnt = 0, en_cyc = 0, err_cyc = 0, stab_viol = 0, xfer_cyc = 0;
    logic [15:0] prev_f [5] = '{default: '0};

    // Reference model state
    int          exp_en = 0, exp_err = 0, exp_drop = 0;
    logic [15:0] exp_f [5] = '{default: '0};
    bit          last_ok = 1'b0;

    always @(posedge clock) begin
        cyc++;
        #1;
        if (en) begin
            en_cnt++;
            en_cyc = cyc;
        end
        if (pkt_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (nrst && !en && ({fsourceID, fdestinationID, fclusterID, fbatteryStat, fValue} !=
                            {prev_f[0], prev_f[1], prev_f[2], prev_f[3], prev_f[4]}))
            stab_viol++;
        prev_f[0] = fsourceID;
        prev_f[1] = fdestinationID;
        prev_f[2] = fclusterID;
        prev_f[3] = fbatteryStat;
        prev_f[4] = fValue;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_f(input string tag);
        check_val({tag, "_src"}, 32'(fsourceID), 32'(exp_f[0]));
        check_val({tag, "_dst"}, 32'(fdestinationID), 32'(exp_f[1]));
        check_val({tag, "_clu"}, 32'(fclusterID), 32'(exp_f[2]));
        check_val({tag, "_bat"}, 32'(fbatteryStat), 32'(exp_f[3]));
        check_val({tag, "_val"}, 32'(fValue), 32'(exp_f[4]));
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) check_val("send_wait", 32'(in_ready), 32'd1);
        xfer_cyc = cyc;
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic send_pkt(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] clu,
                            input logic [15:0] bat, input logic [15:0] val, input bit bad_chk);
        logic [15:0] sum;
        bit dest_ok, chk_ok;
        sum = src + dst + clu + bat + val;
        send_word(SYNC);
        send_word(src);
        send_word(dst);
        send_word(clu);
        send_word(bat);
        send_word(val);
`ifdef PKT_CHECKSUM_EN
        send_word(bad_chk ? sum + 16'd1 : sum);
        chk_ok = !bad_chk;
`else
        chk_ok = 1'b1;
`endif
        dest_ok = (dst == NODE) || (dst == BCAST);
        last_ok = dest_ok && chk_ok;
        if (!dest_ok || !chk_ok) begin
            if (exp_drop < 255) exp_drop++;
            if (dest_ok) exp_err++;
        end else begin
            exp_en++;
            exp_f[0] = src;
            exp_f[1] = dst;
            exp_f[2] = clu;
            exp_f[3] = bat;
            exp_f[4] = val;
        end
    endtask

    task automatic check_outcome(input string tag);
        repeat (3) @(negedge clock);
        check_val({tag, "_en"}, 32'(en_cnt), 32'(exp_en));
        check_val({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
        check_val({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
        check_f(tag);
        check_val({tag, "_rdy"}, 32'(in_ready), last_ok ? 32'd0 : 32'd1);
        if (last_ok) check_val({tag, "_lat"}, 32'(en_cyc - xfer_cyc), 32'd2);
    endtask

    task automatic release_wait(input int delay, input string tag);
        repeat (delay) @(negedge clock);
        done_reward = 1'b1;
        @(negedge clock);
        done_reward = 1'b0;
        check_val({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        nrst = 1'b0;
        repeat (2) @(negedge clock);
        check_val({tag, "_rst_rdy"}, 32'(in_ready), 32'd0);
        check_val({tag, "_rst_en"}, 32'(en), 32'd0);
        check_val({tag, "_rst_perr"}, 32'(pkt_err), 32'd0);
        check_val({tag, "_rst_drop"}, 32'(drop_cnt), 32'd0);
        exp_drop = 0;
        for (int k = 0; k < 5; k++) exp_f[k] = '0;
        check_f({tag, "_rst"});
        nrst = 1'b1;
        @(negedge clock);
        check_val({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
        check_val({tag, "_rst_enc"}, 32'(en_cnt), 32'(exp_en));
        check_val({tag, "_rst_errc"}, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        int          n, d, bp_seen;
        logic [15:0] dst, g;

        @(negedge clock);
        do_reset("init");

        // Garbage before sync, then the nominal packet
        send_word(16'h1234);
        send_word(16'hA5A4);
        send_pkt(16'h000F, 16'h0003, 16'h0001, 16'h5999, 16'h04C4, 1'b0);
        check_outcome("nominal");
        release_wait(5, "nominal");

        send_pkt(16'h000F, 16'h0003, 16'h0001, 16'h5999, 16'h04C4, 1'b1);
        check_outcome("badchk");
        if (last_ok) release_wait(2, "badchk");

        send_pkt(16'h000F, 16'h0007, 16'h0001, 16'h5999, 16'h04C4, 1'b0);
        check_outcome("foreign");
        send_pkt(16'h0011, 16'hFFFF, 16'h0002, 16'h7FFF, 16'h1234, 1'b0);
        check_outcome("bcast");
        release_wait(3, "bcast");

        // Back-pressure: second packet offered immediately, done_reward 20 cycles after en
        send_pkt(16'h0021, 16'h0003, 16'h0004, 16'h4000, 16'h0ABC, 1'b0);
        check_outcome("bp1");
        in_valid = 1'b1;
        in_data  = SYNC;
        bp_seen  = 0;
        repeat (18) begin
            @(negedge clock);
            if (in_ready) bp_seen++;
        end
        check_val("bp_held", 32'(bp_seen), 32'd0);
        release_wait(0, "bp1");
        in_valid = 1'b0;
        send_pkt(16'h0022, 16'h0003, 16'h0005, 16'h2000, 16'h0DEF, 1'b0);
        check_outcome("bp2");
        release_wait(4, "bp2");

        // Timeout
        send_pkt(16'h0031, 16'h0003, 16'h0006, 16'h1000, 16'h0101, 1'b0);
        check_outcome("to");
        n = 0;
        d = err_cnt;
        while (err_cnt == d && n < TO + 50) begin
            @(negedge clock);
            n++;
        end
        check_val("to_seen", 32'(err_cnt), 32'(d + 1));
        check_val("to_lat_ok", 32'((err_cyc - en_cyc >= TO) && (err_cyc - en_cyc <= TO + 3)), 32'd1);
        exp_err++;
        if (exp_drop < 255) exp_drop++;
        check_val("to_drop", 32'(drop_cnt), 32'(exp_drop));
        check_val("to_rdy", 32'(in_ready), 32'd1);
        done_reward = 1'b1;
        @(negedge clock);
        done_reward = 1'b0;
        repeat (2) @(negedge clock);
        check_val("late_done_en", 32'(en_cnt), 32'(exp_en));
        check_val("late_done_err", 32'(err_cnt), 32'(exp_err));
        check_val("late_done_drop", 32'(drop_cnt), 32'(exp_drop));
        send_pkt(16'h0032, 16'hFFFF, 16'h0007, 16'h0800, 16'h0202, 1'b0);
        check_outcome("after_to");
        release_wait(1, "after_to");

        // Reset mid-packet after word 3
        send_word(SYNC);
        send_word(16'h0041);
        send_word(16'h0003);
        send_word(16'h0008);
        do_reset("midpkt");
        send_word(16'h1234);
        send_word(16'hA5A4);
        send_pkt(16'h000F, 16'h0003, 16'h0001, 16'h5999, 16'h04C4, 1'b0);
        check_outcome("post_rst");

        // Reset mid-WAIT
        do_reset("midwait");

        // Randomized packets
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 16'($urandom);
                if (g == SYNC) g = 16'h0000;
                send_word(g);
            end
            d = int'($urandom_range(0, 3));
            if (d < 2) dst = NODE;
            else if (d == 2) dst = BCAST;
            else begin
                dst = 16'($urandom);
                if (dst == NODE || dst == BCAST) dst = 16'h0009;
            end
            send_pkt(16'($urandom), dst, 16'($urandom), 16'($urandom), 16'($urandom),
                     (d < 3) && ($urandom_range(0, 3) == 0));
            check_outcome("rand");
            if (last_ok) release_wait(int'($urandom_range(1, 25)), "rand");
        end

        // drop_cnt saturation
        for (int i = 0; i < 260; i++) begin
            send_pkt(16'($urandom), 16'h0007, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            repeat (2) @(negedge clock);
        end
        check_val("sat_model", 32'(exp_drop), 32'd255);
        check_val("sat_drop", 32'(drop_cnt), 32'(exp_drop));
        check_val("sat_en", 32'(en_cnt), 32'(exp_en));
        check_val("f_stable", 32'(stab_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
